// File: rtl/vitals_link_pkg.sv
// Shared constants, FSM state types and shift-add helpers for the vitals UART link.
package vitals_link_pkg;

  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_L     = 8'h4C;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  localparam int TELEM_LEN  = 8;
  localparam int LEDCMD_LEN = 5;

  typedef enum logic [1:0] {RX_IDLE, RX_COLON, RX_DIG, RX_LF} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_SEND}                  tx_state_t;

  function automatic logic [9:0] times10(input logic [9:0] x);
    return (x << 3) + (x << 1);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_ZERO) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/vitals_frame_parser.sv
// Telemetry frame parser: "S:" + 5 LSD-first digits + LF -> heart rate and SpO2,
// with an inter-byte timeout while a frame is in progress.
module vitals_frame_parser
  import vitals_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int HR_W           = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_byte,
  input  logic            rx_valid,
  output logic [HR_W-1:0] heart_rate,
  output logic [7:0]      spo2,
  output logic            frame_valid,
  output logic            frame_error
);

  localparam int              NUM_DIGITS = TELEM_LEN - 3;
  localparam logic [2:0]      DIG_LAST   = 3'(NUM_DIGITS - 1);
  localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  rx_state_t        state;
  logic [2:0]       dig_idx;
  logic [3:0]       digits [NUM_DIGITS];
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout;
  rx_state_t        err_state;
  logic [9:0]       hr_new;
  logic [6:0]       spo2_new;

  // A byte arriving on the timeout cycle wins, so rx_valid masks the timeout.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state != RX_IDLE) && !rx_valid
                   && (idle_cnt == CNT_LAST);

  assign hr_new   = times10(times10({6'd0, digits[2]}) + {6'd0, digits[1]}) + {6'd0, digits[0]};
  assign spo2_new = 7'(times10({6'd0, digits[4]}) + {6'd0, digits[3]});

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    err_state = RX_IDLE;
    if (rx_byte == CH_S) err_state = RX_COLON;
  end

  // NOTE: digit storage has no reset; it is only read after a complete frame has rewritten it.
  always_ff @(posedge clk) begin
    if (rx_valid && state == RX_DIG && is_digit(rx_byte)) digits[dig_idx] <= rx_byte[3:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RX_IDLE;
      dig_idx     <= '0;
      idle_cnt    <= '0;
      heart_rate  <= '0;
      spo2        <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (rx_valid)              idle_cnt <= '0;
      else if (state != RX_IDLE) idle_cnt <= idle_cnt + CNT_W'(1);

      if (timeout) begin
        frame_error <= 1'b1;
        state       <= RX_IDLE;
        idle_cnt    <= '0;
      end else if (rx_valid) begin
        unique case (state)
          RX_IDLE: if (rx_byte == CH_S) state <= RX_COLON;
          RX_COLON:
            if (rx_byte == CH_COLON) begin
              state   <= RX_DIG;
              dig_idx <= '0;
            end else begin
              frame_error <= 1'b1;
              state       <= err_state;
            end
          RX_DIG:
            if (is_digit(rx_byte)) begin
              if (dig_idx == DIG_LAST) state <= RX_LF;
              else                     dig_idx <= dig_idx + 3'd1;
            end else begin
              frame_error <= 1'b1;
              state       <= err_state;
            end
          RX_LF:
            if (rx_byte == CH_LF) begin
              heart_rate  <= HR_W'(hr_new);
              spo2        <= {1'b0, spo2_new};
              frame_valid <= 1'b1;
              state       <= RX_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= err_state;
            end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/vitals_link_host.sv
// Host side of the vitals UART link: telemetry parser plus LED command frame encoder.
module vitals_link_host
  import vitals_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int HR_W           = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_byte,
  input  logic            rx_valid,
  output logic [HR_W-1:0] heart_rate,
  output logic [7:0]      spo2,
  output logic            frame_valid,
  output logic            frame_error,
  input  logic            cmd_valid,
  input  logic            cmd_led1,
  input  logic            cmd_led2,
  output logic            cmd_ready,
  output logic [7:0]      tx_byte,
  output logic            tx_valid,
  input  logic            tx_ready
);

  localparam logic [2:0] TX_LAST = 3'(LEDCMD_LEN - 1);

  vitals_frame_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HR_W          (HR_W)
  ) u_parser (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .heart_rate (heart_rate),
    .spo2       (spo2),
    .frame_valid(frame_valid),
    .frame_error(frame_error)
  );

  tx_state_t  tx_state;
  logic [2:0] tx_idx;
  logic       led1_q;
  logic       led2_q;

  function automatic logic [7:0] led_frame_byte(input logic [2:0] idx, input logic l1, input logic l2);
    case (idx)
      3'd0:    return CH_L;
      3'd1:    return CH_COLON;
      3'd2:    return CH_ZERO | {7'd0, l1};
      3'd3:    return CH_ZERO | {7'd0, l2};
      default: return CH_LF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_idx    <= '0;
      led1_q    <= 1'b0;
      led2_q    <= 1'b0;
      cmd_ready <= 1'b1;
      tx_byte   <= 8'h00;
      tx_valid  <= 1'b0;
    end else begin
      unique case (tx_state)
        TX_IDLE:
          if (cmd_valid && cmd_ready) begin
            led1_q    <= cmd_led1;
            led2_q    <= cmd_led2;
            cmd_ready <= 1'b0;
            tx_idx    <= '0;
            tx_byte   <= led_frame_byte(3'd0, cmd_led1, cmd_led2);
            tx_valid  <= 1'b1;
            tx_state  <= TX_SEND;
          end
        TX_SEND:
          // tx_byte only changes on a handshake, so it holds steady through stalls.
          if (tx_ready) begin
            if (tx_idx == TX_LAST) begin
              tx_valid  <= 1'b0;
              cmd_ready <= 1'b1;
              tx_state  <= TX_IDLE;
            end else begin
              tx_idx  <= tx_idx + 3'd1;
              tx_byte <= led_frame_byte(tx_idx + 3'd1, led1_q, led2_q);
            end
          end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vitals_link_host.md
Name: vitals_link_host

Overview:
- Host-side peer of the sensor UART link. Its RX path parses telemetry frames `S:` + 5 ASCII digits + LF into binary heart-rate and SpO2 values. Its TX path encodes LED command frames `L:` + 2 ASCII flags + LF as a byte stream.
- Sits between a byte-level UART core (data-received/done pulse on RX; byte/handshake on TX) and host logic (display, alarm, LED control).

Parameters:
- TIMEOUT_CYCLES, 1_000_000: inter-byte timeout while mid-frame; 0 disables the timeout.
- HR_W, 16: heart_rate output width; must be at least 10.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_byte  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle
- heart_rate  out  HR_W  last good heart rate, 0..999 bpm
- spo2  out  8  last good SpO2, 0..99 %
- frame_valid  out  1  one-cycle pulse when heart_rate/spo2 update
- frame_error  out  1  one-cycle pulse on a malformed or timed-out frame
- cmd_valid  in  1  request to send an LED command
- cmd_led1  in  1  LED1 state to send
- cmd_led2  in  1  LED2 state to send
- cmd_ready  out  1  high when the encoder is idle; a command is accepted when cmd_valid && cmd_ready
- tx_byte  out  8  byte to UART transmitter
- tx_valid  out  1  tx_byte is valid; held until accepted
- tx_ready  in  1  UART transmitter can take a byte; a byte transfers on tx_valid && tx_ready

Behaviour:
- Reset values: heart_rate=0, spo2=0, frame_valid=0, frame_error=0, cmd_ready=1, tx_byte=0x00, tx_valid=0. Both FSMs return to idle.
- Reset asserted mid-frame abandons the frame with no pulses.
- RX frame is exactly 8 bytes: 0x53 `S`, 0x3A `:`, d0 d1 d2 d3 d4, 0x0A LF.
  - Digits are sent least-significant first.
  - HR = d2*100 + d1*10 + d0.
  - SpO2 = d4*10 + d3.
- RX FSM states: IDLE, COLON, DIG(0..4) with a digit index, LF.
  - IDLE: `S` -> COLON; any other byte is discarded silently with no error.
  - COLON: `:` -> DIG0; otherwise error.
  - DIGn: a byte in 0x30..0x39 stores (byte-0x30) and advances; DIG4 -> LF. Any other byte is an error.
  - LF: 0x0A -> compute values, register outputs, pulse frame_valid the next cycle, return to IDLE. Otherwise error.
- RX error handling:
  - Pulse frame_error for 1 cycle; outputs keep their previous values.
  - If the offending byte is `S`, go to COLON (resync); else go to IDLE.
- Arithmetic: use shift-add only (x*10 = (x<<3)+(x<<1)), with no divider. Max HR 999 fits in 10 bits; zero-extend to HR_W.
- Latency: frame_valid rises exactly 1 cycle after the LF rx_valid cycle, with new values visible that same cycle.
- Timeout:
  - The counter runs while the RX FSM is not in IDLE and clears on every rx_valid.
  - On reaching TIMEOUT_CYCLES: frame_error pulse, go to IDLE.
  - If rx_valid coincides with the timeout cycle, the byte wins: it is processed and the counter clears, with no timeout.
- TX FSM states: IDLE, SEND with byte index 0..4.
  - On accept in IDLE, latch the flags and drop cmd_ready.
  - Bytes in order: 0x4C `L`, 0x3A, 0x30+led1, 0x30+led2, 0x0A.
  - tx_valid goes high the cycle after accept; tx_byte is stable while tx_valid && !tx_ready.
  - Index advances on each handshake. After the LF handshake, tx_valid=0 and cmd_ready=1 the next cycle.
  - cmd_valid while busy is ignored; no queuing.
- RX and TX paths are fully independent; simultaneous activity has no interaction.

Decomposition:
- Shared package `vitals_link_pkg`:
  - ASCII constants: CH_S, CH_L, CH_COLON, CH_LF, CH_ZERO.
  - Frame lengths: TELEM_LEN=8, LEDCMD_LEN=5.
  - RX and TX FSM state enums.
- One sub-module: `vitals_frame_parser` (the RX FSM, digit registers, timeout and value computation). The TX encoder stays in the top.

Test Plan:
- RX "S:57089\n" at 1 byte per 16 cycles -> one frame_valid pulse, heart_rate=75, spo2=98, frame_error never high.
- RX "S:521" then "X08\n" -> frame_error pulse on X, outputs unchanged; then "S:000" "00\n" -> heart_rate=0, spo2=0, frame_valid pulse.
- RX "S:5S:99919\n" -> error on the second S, resync on it, final heart_rate=999, spo2=91.
- RX "S:12", then idle for TIMEOUT_CYCLES (bench TIMEOUT_CYCLES=50) -> frame_error exactly at cycle 50; a byte landing on cycle 50 instead produces no error.
- cmd_valid with led1=1, led2=0, tx_ready toggling 1/0 -> bytes 0x4C 0x3A 0x31 0x30 0x0A in order, tx_byte stable during stalls; a second cmd_valid mid-frame is ignored; cmd_ready returns high 1 cycle after the last handshake.
- Assert rst_n low mid RX frame and mid TX frame -> all outputs at reset values; next full frames on both paths succeed.
